switch_button_debouncer: RTL and testbench
==========================================

Name: switch_button_debouncer

Overview:
- Input-side counterpart to the 7-segment display driver: conditions raw board switches and push-buttons into clean, clock-synchronous signals for the memory controller.
- Each raw input passes through a 2-flop synchronizer and a consecutive-sample debounce counter.
- Switches yield stable levels. Buttons yield stable levels plus single-cycle press and release pulses.

Parameters:
- NUM_SW, 2, number of slide-switch channels (memory write/read block selects).
- NUM_BTN, 2, number of push-button channels.
- DEBOUNCE_CYCLES, 16, consecutive mismatching samples required to accept a new level; legal range 2..65535.
- REPEAT_CYCLES, 64, auto-repeat period in clocks; used only when AUTO_REPEAT_EN is defined; minimum 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; assertion clears all state immediately.
- sw_raw  input  NUM_SW  raw switch pins, asynchronous to clock.
- btn_raw  input  NUM_BTN  raw button pins, asynchronous to clock, active-high.
- sw_level  output  NUM_SW  debounced switch levels.
- btn_level  output  NUM_BTN  debounced button levels.
- btn_press  output  NUM_BTN  one-cycle pulse per accepted 0->1 button transition.
- btn_release  output  NUM_BTN  one-cycle pulse per accepted 1->0 button transition.

Behaviour:
- Reset (reset=0): sync flops, debounce counters, stable levels, pulses and repeat counters all go to 0. All outputs read 0.
- Channel datapath, identical for every switch and button:
  - Synchronizer: s1 <= raw; s2 <= s1.
  - Debounce, when s2 != stable:
    - if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
    - else: cnt <= cnt+1.
  - Debounce, when s2 == stable: cnt <= 0.
- Counter width is clog2(DEBOUNCE_CYCLES). The counter never wraps, because it saturates into the accept condition.
- Latency: a clean raw step is reflected on *_level on the (DEBOUNCE_CYCLES+2)th rising edge. The first edge that samples the new raw value counts as edge 1.
- Glitch rejection: any return of s2 to the stable value before acceptance clears cnt. Runs shorter than DEBOUNCE_CYCLES samples produce no output change and no pulse.
- Pulses:
  - btn_press[i] is a registered output, high for exactly one cycle, on the same edge that btn_level[i] goes 0->1.
  - btn_release[i] behaves the same way for the 1->0 transition.
  - Press and release can never be high together on one channel.
- Channels are fully independent. Simultaneous transitions on several inputs are each handled normally, with no arbitration.
- Reset mid-debounce: the partial count is discarded. After reset deasserts with raw held high, the level rises after DEBOUNCE_CYCLES+2 edges and btn_press fires once.
- Switch channels have no pulse outputs.

Optional Feature:
- Macro: SWITCH_BUTTON_AUTO_REPEAT_EN.
- When defined:
  - Each button has a repeat counter, cleared on press and whenever btn_level=0.
  - While btn_level stays 1, btn_press re-pulses for one cycle REPEAT_CYCLES clocks after the initial press, then every REPEAT_CYCLES clocks.
  - Release clears the counter and suppresses any pending repeat.
  - btn_release is unaffected.
- When undefined:
  - No repeat logic is generated.
  - Exactly one btn_press per accepted press.
  - REPEAT_CYCLES is ignored.

Decomposition:
- Shared package switch_button_pkg holds:
  - default constants DEBOUNCE_CYCLES_DEF=16 and REPEAT_CYCLES_DEF=64;
  - a localparam function returning the counter width;
  - typedef debounce_cnt_t.
- Sub-module debounce_channel contains the sync flops, counter, stable register and edge pulses, with an optional repeat block.
- debounce_channel is instantiated NUM_SW+NUM_BTN times via generate. Pulse outputs are left unconnected for switch instances.

Test Plan:
- Reset then clean step: DEBOUNCE_CYCLES=16, btn_raw[0] 0->1 and held -> btn_level[0]=1 on edge 18, btn_press[0]=1 on edge 18 only, btn_release stays 0.
- Bounce rejection: sw_raw[1] toggles high for 10 cycles, low 3, high 15, low -> sw_level[1] stays 0 throughout; then held high 20 cycles -> sw_level[1]=1 on edge 18 of the final run.
- Release: btn_raw[1] held high until accepted, then dropped to 0 -> btn_level[1]=0 and btn_release[1]=1 for one cycle 18 edges later, no btn_press.
- Simultaneous: sw_raw=2'b11 and btn_raw=2'b11 on the same edge -> all four levels rise on the same edge 18, with both press pulses coincident.
- Async reset mid-count: assert reset at edge 10 of a 0->1 run -> all outputs 0 immediately; deassert with raw still high -> level and press pulse 18 edges after deassertion.
- With SWITCH_BUTTON_AUTO_REPEAT_EN and REPEAT_CYCLES=64, hold btn_raw[0] for 200 cycles after acceptance -> btn_press pulses at acceptance, then +64 and +128, with none after release.

Source files
------------

// File: rtl/switch_button_debouncer_pkg.sv
// Shared constants, the counter-width helper and the default debounce counter type
// for the switch/button input conditioner.
package switch_button_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int REPEAT_CYCLES_DEF   = 64;

    // A counter must hold values up to cycles-1; keep at least one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

    typedef logic [cnt_width(DEBOUNCE_CYCLES_DEF)-1:0] debounce_cnt_t;

endpackage

// File: rtl/switch_button_debouncer_if.sv
// Raw pin inputs and conditioned outputs of the switch/button debouncer.
// The master drives the raw pins; the slave (the debouncer) drives the cleaned signals.
interface switch_button_debouncer_if #(
    parameter int NUM_SW  = 2,
    parameter int NUM_BTN = 2
);

    logic [NUM_SW-1:0]  sw_raw;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_SW-1:0]  sw_level;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;

    modport master (
        output sw_raw,
        output btn_raw,
        input  sw_level,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  sw_raw,
        input  btn_raw,
        output sw_level,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/switch_button_debouncer_channel.sv
// One input channel: 2-flop synchronizer, consecutive-sample debounce counter,
// stable level and registered edge pulses. Auto-repeat under SWITCH_BUTTON_AUTO_REPEAT_EN.
module debounce_channel
    import switch_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("debounce_channel: DEBOUNCE_CYCLES out of range 2..65535");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("debounce_channel: REPEAT_CYCLES must be at least 2");
    end

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          accept;
    logic          repeat_fire;

    // The counter saturates into the accept condition, so it never wraps.
    assign accept = (sync2_q != stable_q) && (cnt_q == CNT_MAX);

    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync2_q != stable_q) begin
            if (accept) begin
                stable_d  = sync2_q;
                cnt_d     = '0;
                press_d   = sync2_q;
                release_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
        if (repeat_fire) begin
            press_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw_i;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

`ifdef SWITCH_BUTTON_AUTO_REPEAT_EN
    localparam int            RW      = cnt_width(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q;

    // Held while the level is low and on any accept, so a release kills a pending repeat.
    assign repeat_fire = stable_q && !accept && (rep_q == REP_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rep_q <= '0;
        end else if (!stable_q || accept || repeat_fire) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_q + RW'(1);
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign level_o   = stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/switch_button_debouncer.sv
// Conditions raw switches and push-buttons into clean synchronous levels and button pulses.
// Define SWITCH_BUTTON_AUTO_REPEAT_EN to enable held-button press auto-repeat.
module switch_button_debouncer
    import switch_button_pkg::*;
#(
    parameter int NUM_SW          = 2,
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    switch_button_debouncer_if.slave bus
);

    // Switches have no pulse outputs; these collect the channel pulse pins.
    logic [NUM_SW-1:0] sw_press_unused;
    logic [NUM_SW-1:0] sw_release_unused;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .raw_i     (bus.sw_raw[i]),
            .level_o   (bus.sw_level[i]),
            .press_o   (sw_press_unused[i]),
            .release_o (sw_release_unused[i])
        );
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .raw_i     (bus.btn_raw[i]),
            .level_o   (bus.btn_level[i]),
            .press_o   (bus.btn_press[i]),
            .release_o (bus.btn_release[i])
        );
    end

endmodule

// File: tb/tb_switch_button_debouncer.sv
// Directed self-checking bench for switch_button_debouncer (DEBOUNCE_CYCLES=16, REPEAT_CYCLES=64).
module tb_switch_button_debouncer;

    localparam int DB = 16;
    localparam int RP = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    switch_button_debouncer_if #(.NUM_SW(2), .NUM_BTN(2)) bus ();

    switch_button_debouncer #(
        .NUM_SW          (2),
        .NUM_BTN         (2),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (RP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic apply_reset();
        bus.sw_raw  = 2'b00;
        bus.btn_raw = 2'b00;
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(3);
    endtask

    function automatic logic [7:0] all_outs();
        return {bus.sw_level, bus.btn_level, bus.btn_press, bus.btn_release};
    endfunction

    int    run_len [4];
    logic  run_val [4];
    logic  rep_exp;

    initial begin
        bus.sw_raw  = 2'b00;
        bus.btn_raw = 2'b00;

        // Reset state
        tick(3);
        check("reset_outs", all_outs(), 8'h00);
        reset = 1'b1;
        tick(2);
        check("post_reset_outs", all_outs(), 8'h00);

        // Clean step on btn_raw[0]
        bus.btn_raw[0] = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick(1);
            check("step_level", {7'd0, bus.btn_level[0]}, {7'd0, e >= 18});
            check("step_press", {6'd0, bus.btn_press}, {7'd0, e == 18});
            check("step_release", {6'd0, bus.btn_release}, 8'h00);
        end

        // Bounce rejection on sw_raw[1]
        apply_reset();
        run_len[0] = 10; run_val[0] = 1'b1;
        run_len[1] = 3;  run_val[1] = 1'b0;
        run_len[2] = 15; run_val[2] = 1'b1;
        run_len[3] = 5;  run_val[3] = 1'b0;
        for (int r = 0; r < 4; r++) begin
            bus.sw_raw[1] = run_val[r];
            for (int c = 0; c < run_len[r]; c++) begin
                tick(1);
                check("bounce_level", {6'd0, bus.sw_level}, 8'h00);
            end
        end
        bus.sw_raw[1] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick(1);
            check("bounce_final", {6'd0, bus.sw_level}, {6'd0, e >= 18, 1'b0});
        end

        // Release on btn_raw[1]
        apply_reset();
        bus.btn_raw[1] = 1'b1;
        tick(18);
        check("rel_accept_level", {6'd0, bus.btn_level}, 8'h02);
        check("rel_accept_press", {6'd0, bus.btn_press}, 8'h02);
        tick(1);
        bus.btn_raw[1] = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            tick(1);
            check("rel_level", {6'd0, bus.btn_level}, {6'd0, e < 18, 1'b0});
            check("rel_pulse", {6'd0, bus.btn_release}, {6'd0, e == 18, 1'b0});
            check("rel_no_press", {6'd0, bus.btn_press}, 8'h00);
        end

        // Simultaneous transitions on all four channels
        apply_reset();
        bus.sw_raw  = 2'b11;
        bus.btn_raw = 2'b11;
        tick(17);
        check("simul_before", all_outs(), 8'h00);
        tick(1);
        check("simul_accept", all_outs(), 8'hFC);
        tick(1);
        check("simul_after", all_outs(), 8'hF0);

        // Async reset mid-count, with an already accepted switch level
        apply_reset();
        bus.sw_raw[0] = 1'b1;
        tick(18);
        check("mid_sw_level", {6'd0, bus.sw_level}, 8'h01);
        bus.btn_raw[0] = 1'b1;
        tick(10);
        reset = 1'b0;
        #1;
        check("mid_reset_outs", all_outs(), 8'h00);
        #1;
        reset = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            tick(1);
            check("mid_btn_level", {7'd0, bus.btn_level[0]}, {7'd0, e >= 18});
            check("mid_sw_level2", {7'd0, bus.sw_level[0]}, {7'd0, e >= 18});
            check("mid_press", {6'd0, bus.btn_press}, {7'd0, e == 18});
        end

        // Held button: repeat pulses only when auto-repeat is built in
        for (int k = 1; k <= 170; k++) begin
            tick(1);
`ifdef SWITCH_BUTTON_AUTO_REPEAT_EN
            rep_exp = (k == RP) || (k == 2 * RP);
`else
            rep_exp = 1'b0;
`endif
            check("hold_press", {6'd0, bus.btn_press}, {7'd0, rep_exp});
        end
        bus.btn_raw[0] = 1'b0;
        for (int e = 1; e <= 80; e++) begin
            tick(1);
            check("drop_press", {6'd0, bus.btn_press}, 8'h00);
            check("drop_release", {6'd0, bus.btn_release}, {7'd0, e == 18});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
